image_buffer: RTL and testbench
===============================

// Module: image_buffer
// PURPOSE
// - Upstream stage of the softmax inference engine: assembles 784-byte signed pixel frames from the UART RX byte stream into a ping-pong image RAM.
// - Serves pixels to the inference engine via a 1-cycle-latency read port and issues start_inference once per complete frame.
// - Double buffering lets frame N+1 arrive over UART while frame N is being classified.
// PARAMETERS
// - NUM_PIXELS      784        bytes per frame; one RAM bank depth
// - TIMEOUT_CYCLES  1000000    idle cycles inside a partial frame before it is discarded (10 ms at 100 MHz)
// PORTS
// - clk              in   1   system clock
// - rst_n            in   1   asynchronous active-low reset
// - rx_data          in   8   received byte (two's-complement pixel)
// - rx_valid         in   1   1-cycle strobe, rx_data valid
// - weights_ready    in   1   weights loaded; start is withheld while low
// - inf_busy         in   1   busy from inference engine
// - inference_done   in   1   1-cycle done pulse from inference engine
// - input_addr       in   10  pixel index requested by inference engine (0..783)
// - input_pixel      out  8   mem[rd_bank][input_addr], registered
// - start_inference  out  1   1-cycle start pulse
// - bank_full        out  2   per-bank "holds committed, unconsumed frame" flags
// - frame_error      out  1   1-cycle pulse: frame discarded (timeout or checksum)
// - overflow         out  1   1-cycle pulse: byte dropped, no free bank
// BEHAVIOUR
// - Reset (async, rst_n=0): input_pixel=0, start_inference=0, bank_full=2'b00, frame_error=0, overflow=0; wr_bank=0, rd_bank=0, wr_cnt=0, running=0, timer=0. RAM contents not cleared. Reset mid-frame or mid-inference abandons both; no pulses on release.
// - Write FSM states: W_FILL (accept bytes), W_CHK (macro only), W_COMMIT (1 cycle), W_STALL.
// - W_FILL: rx_valid -> mem[wr_bank][wr_cnt]<=rx_data, wr_cnt++, timer<=0. Byte 784 -> W_COMMIT (or W_CHK with macro). No rx_valid while wr_cnt>0: timer++; timer==TIMEOUT_CYCLES-1 -> wr_cnt<=0, timer<=0, frame_error pulse, stay W_FILL. Timer idle while wr_cnt==0.
// - W_COMMIT: bank_full[wr_bank]<=1, wr_cnt<=0; other bank free -> wr_bank toggles, W_FILL; else W_STALL.
// - W_STALL: every rx_valid dropped with overflow pulse; when bank_full[~wr_bank] clears -> wr_bank toggles, W_FILL (transition visible the cycle after release).
// - Start logic: running==0 && inf_busy==0 && weights_ready && bank_full[k] -> start_inference=1 for exactly one cycle, rd_bank<=k, running<=1. Both banks full: oldest (the bank NOT equal to wr_bank-after-commit, i.e. commit order) first.
// - inference_done while running -> bank_full[rd_bank]<=0, running<=0. Earliest next start: cycle after release.
// - inference_done while running==0: ignored.
// - Simultaneous commit and release in one cycle: both applied (different banks); no lost frame.
// - Read port: input_pixel <= mem[rd_bank][input_addr] every cycle, 1-cycle latency, matching weight memory latency. input_addr >= NUM_PIXELS returns undefined data (engine never issues it).
// - wr_cnt 10 bit, saturates via commit; timer width $clog2(TIMEOUT_CYCLES).
// CONFIGURATION
// - IMG_CHECKSUM_EN defined: after byte 784 FSM enters W_CHK and waits for one more byte (same timeout rule). Byte == sum of 784 pixel bytes mod 256 -> W_COMMIT; mismatch -> frame_error pulse, wr_cnt<=0, W_FILL, bank not committed.
// - IMG_CHECKSUM_EN undefined: no W_CHK; frame commits directly after byte 784; frame_error only from timeout.
// TESTING
// - Reset, send 784 bytes (value = index[7:0]), weights_ready=1 -> bank_full=01, start_inference one pulse ~2 cycles after last byte; input_addr=5 -> input_pixel=8'h05 next cycle.
// - Send 400 bytes then idle TIMEOUT_CYCLES (override to 100) -> frame_error pulse at cycle 100, bank_full stays 00; next 784 bytes commit normally.
// - Two frames back to back with inf_busy held high -> bank_full=11, no start; third frame's bytes each raise overflow; done pulse -> bank 0 released, start for bank 1 next eligible cycle.
// - weights_ready=0 with full frame -> no start; raise weights_ready -> exactly one start pulse.
// - IMG_CHECKSUM_EN: correct checksum -> commit; checksum+1 -> frame_error, bank_full 00.
// - Assert rst_n low mid-frame and mid-inference -> all outputs at reset values immediately, fresh frame then commits into bank 0.

Source files
------------

// File: rtl/image_buffer.sv
// Ping-pong image RAM filled from UART bytes; 1-cycle read port, one start pulse per committed frame.
// Bytes with no free bank raise overflow. Define IMG_CHECKSUM_EN to require a mod-256 sum byte per frame.
module image_buffer #(
  parameter int NUM_PIXELS     = 784,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       weights_ready,
  input  logic       inf_busy,
  input  logic       inference_done,
  input  logic [9:0] input_addr,
  output logic [7:0] input_pixel,
  output logic       start_inference,
  output logic [1:0] bank_full,
  output logic       frame_error,
  output logic       overflow
);

  localparam int            TW         = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0]    CNT_LAST   = 10'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {W_FILL, W_CHK, W_COMMIT, W_STALL} wr_state_t;

  wr_state_t     state, state_nx;
  logic [7:0]    mem [2][NUM_PIXELS];
  logic          wr_bank, rd_bank, running;
  logic [9:0]    wr_cnt;
  logic [TW-1:0] timer;
  logic          wr_en, cnt_inc, cnt_clr, timer_inc, timer_clr;
  logic          err_set, ovf_set, commit, toggle, timed_out;
  logic          release_bank, start_ok, start_bank;
  logic [1:0]    bank_full_nx;
`ifdef IMG_CHECKSUM_EN
  logic [7:0]    sum;
`endif

  // Idle timer only matters once a frame is partially received.
  assign timed_out = (wr_cnt != 10'd0) && (timer == TIMER_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= W_FILL;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    wr_en     = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    timer_inc = 1'b0;
    timer_clr = 1'b0;
    err_set   = 1'b0;
    ovf_set   = 1'b0;
    commit    = 1'b0;
    toggle    = 1'b0;
    unique case (state)
      W_FILL: begin
        if (rx_valid) begin
          wr_en     = 1'b1;
          cnt_inc   = 1'b1;
          timer_clr = 1'b1;
          if (wr_cnt == CNT_LAST) begin
`ifdef IMG_CHECKSUM_EN
            state_nx = W_CHK;
`else
            state_nx = W_COMMIT;
`endif
          end
        end else if (timed_out) begin
          cnt_clr   = 1'b1;
          timer_clr = 1'b1;
          err_set   = 1'b1;
        end else if (wr_cnt != 10'd0) begin
          timer_inc = 1'b1;
        end
      end
`ifdef IMG_CHECKSUM_EN
      W_CHK: begin
        if (rx_valid) begin
          timer_clr = 1'b1;
          if (rx_data == sum) begin
            state_nx = W_COMMIT;
          end else begin
            err_set  = 1'b1;
            cnt_clr  = 1'b1;
            state_nx = W_FILL;
          end
        end else if (timed_out) begin
          cnt_clr   = 1'b1;
          timer_clr = 1'b1;
          err_set   = 1'b1;
          state_nx  = W_FILL;
        end else begin
          timer_inc = 1'b1;
        end
      end
`endif
      W_COMMIT: begin
        commit  = 1'b1;
        cnt_clr = 1'b1;
        if (!bank_full[~wr_bank]) begin
          toggle   = 1'b1;
          state_nx = W_FILL;
        end else begin
          state_nx = W_STALL;
        end
      end
      W_STALL: begin
        ovf_set = rx_valid;
        if (!bank_full[~wr_bank]) begin
          toggle   = 1'b1;
          state_nx = W_FILL;
        end
      end
      default: state_nx = W_FILL;
    endcase
  end

  assign release_bank = inference_done && running;
  assign start_ok     = !running && !inf_busy && weights_ready && (bank_full != 2'b00);
  // With both banks full the writer sits on the newest one, so the other is oldest.
  assign start_bank   = (bank_full == 2'b11) ? ~wr_bank : bank_full[1];

  // Commit and release always target different banks, so both may land together.
  always_comb begin
    bank_full_nx = bank_full;
    if (commit)       bank_full_nx[wr_bank] = 1'b1;
    if (release_bank) bank_full_nx[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank         <= 1'b0;
      rd_bank         <= 1'b0;
      running         <= 1'b0;
      wr_cnt          <= 10'd0;
      timer           <= '0;
      bank_full       <= 2'b00;
      start_inference <= 1'b0;
      frame_error     <= 1'b0;
      overflow        <= 1'b0;
      input_pixel     <= 8'd0;
`ifdef IMG_CHECKSUM_EN
      sum             <= 8'd0;
`endif
    end else begin
      if (toggle) wr_bank <= ~wr_bank;
      if (cnt_clr)      wr_cnt <= 10'd0;
      else if (cnt_inc) wr_cnt <= wr_cnt + 10'd1;
      if (timer_clr)      timer <= '0;
      else if (timer_inc) timer <= timer + TW'(1);
      bank_full       <= bank_full_nx;
      start_inference <= start_ok;
      frame_error     <= err_set;
      overflow        <= ovf_set;
      if (start_ok) begin
        rd_bank <= start_bank;
        running <= 1'b1;
      end else if (release_bank) begin
        running <= 1'b0;
      end
      input_pixel <= mem[rd_bank][input_addr];
`ifdef IMG_CHECKSUM_EN
      if (wr_en) sum <= (wr_cnt == 10'd0) ? rx_data : sum + rx_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_cnt] <= rx_data;
  end

endmodule

// File: tb/tb_image_buffer.sv
// Randomized bench for image_buffer: a queue-based frame model predicts every output each cycle.
`timescale 1ns/1ps
module tb_image_buffer;
  localparam int NP = 784;
  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       rx_valid = 1'b0;
  logic       weights_ready = 1'b0;
  logic       inf_busy;
  logic       inference_done;
  logic [9:0] input_addr;
  logic [7:0] input_pixel;
  logic       start_inference;
  logic [1:0] bank_full;
  logic       frame_error;
  logic       overflow;

  image_buffer #(.NUM_PIXELS(NP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .weights_ready(weights_ready), .inf_busy(inf_busy), .inference_done(inference_done),
    .input_addr(input_addr), .input_pixel(input_pixel), .start_inference(start_inference),
    .bank_full(bank_full), .frame_error(frame_error), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frames are tracked as a commit-ordered queue of banks.
  logic [7:0] m_mem [2][NP];
  bit         m_vld [2][NP];
  int         full_q[$];
  int         m_wb = 0, m_rd = 0, m_cnt = 0, m_idle = 0;
  bit         m_run = 0, m_pend = 0, m_stall = 0, m_chk = 0;
  logic [7:0] m_sum = 8'd0;
  bit         e_start = 0, e_err = 0, e_ovf = 0, e_pix_vld = 1;
  logic [7:0] e_pix = 8'd0;
  bit         old_full [2];
  bit         go;

  function automatic logic [1:0] exp_bank_full();
    logic [1:0] r = 2'b00;
    foreach (full_q[i]) r[full_q[i]] = 1'b1;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q.delete();
      m_wb = 0; m_rd = 0; m_cnt = 0; m_idle = 0;
      m_run = 0; m_pend = 0; m_stall = 0; m_chk = 0; m_sum = 8'd0;
      e_start = 0; e_err = 0; e_ovf = 0; e_pix = 8'd0; e_pix_vld = 1;
    end else begin
      old_full[0] = 0;
      old_full[1] = 0;
      foreach (full_q[i]) old_full[full_q[i]] = 1;
      e_pix_vld = (int'(input_addr) < NP) && m_vld[m_rd][input_addr];
      if (e_pix_vld) e_pix = m_mem[m_rd][input_addr];
      go = !m_run && !inf_busy && weights_ready && (full_q.size() > 0);
      e_start = go;
      e_err = 0;
      e_ovf = 0;
      if (m_run && inference_done) begin
        for (int i = 0; i < full_q.size(); i++)
          if (full_q[i] == m_rd) begin full_q.delete(i); break; end
        m_run = 0;
      end
      if (go) begin
        m_rd = full_q[0];
        m_run = 1;
      end
      if (m_pend) begin
        full_q.push_back(m_wb);
        m_pend = 0;
        m_cnt = 0;
        if (!old_full[1-m_wb]) m_wb = 1 - m_wb;
        else m_stall = 1;
      end else if (m_stall) begin
        if (rx_valid) e_ovf = 1;
        if (!old_full[1-m_wb]) begin m_wb = 1 - m_wb; m_stall = 0; end
      end else if (rx_valid) begin
        m_idle = 0;
        if (m_chk) begin
          m_chk = 0;
          if (rx_data == m_sum) m_pend = 1;
          else begin e_err = 1; m_cnt = 0; end
        end else begin
          m_mem[m_wb][m_cnt] = rx_data;
          m_vld[m_wb][m_cnt] = 1;
          m_sum = (m_cnt == 0) ? rx_data : m_sum + rx_data;
          m_cnt++;
          if (m_cnt == NP) begin
`ifdef IMG_CHECKSUM_EN
            m_chk = 1;
`else
            m_pend = 1;
`endif
          end
        end
      end else if (m_cnt > 0) begin
        m_idle++;
        if (m_idle == TO) begin e_err = 1; m_cnt = 0; m_idle = 0; m_chk = 0; end
      end
    end
  end

  always @(negedge clk) begin
    chk("start_inference", 16'(start_inference), 16'(e_start));
    chk("bank_full", 16'(bank_full), 16'(exp_bank_full()));
    chk("frame_error", 16'(frame_error), 16'(e_err));
    chk("overflow", 16'(overflow), 16'(e_ovf));
    if (e_pix_vld) chk("input_pixel", 16'(input_pixel), 16'(e_pix));
  end

  // Inference engine stand-in: busy for a random time after each predicted start.
  bit hold = 0, force_busy = 0, spurious = 0, rand_addr = 0, eng_run = 0;
  int busy_cnt = 0;
  logic [9:0] addr_fix = 10'd0;

  initial begin
    inf_busy = 1'b0;
    inference_done = 1'b0;
    input_addr = 10'd0;
    forever begin
      @(negedge clk);
      inference_done = 1'b0;
      if (!rst_n) begin
        eng_run = 0;
      end else if (eng_run) begin
        if (!hold) begin
          if (busy_cnt == 0) begin inference_done = 1'b1; eng_run = 0; end
          else busy_cnt--;
        end
      end else if (e_start) begin
        eng_run = 1;
        busy_cnt = $urandom_range(3, 40);
      end else if (spurious && $urandom_range(0, 63) == 0) begin
        inference_done = 1'b1;
      end
      inf_busy = eng_run || force_busy;
      input_addr = rand_addr ? 10'($urandom_range(0, NP - 1)) : addr_fix;
    end
  end

  task automatic send_byte(input logic [7:0] d, input int gap);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = d;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input int kind, input int last_gap);
    logic [7:0] d;
`ifdef IMG_CHECKSUM_EN
    logic [7:0] s = 8'd0;
`endif
    for (int i = 0; i < NP; i++) begin
      d = (kind == 0) ? 8'(i) : 8'($urandom);
`ifdef IMG_CHECKSUM_EN
      s = s + d;
      send_byte(d, $urandom_range(0, 2));
    end
    send_byte(s, last_gap);
`else
      send_byte(d, (i == NP - 1) ? last_gap : $urandom_range(0, 2));
    end
`endif
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((full_q.size() != 0 || m_run || m_stall || m_pend) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d cycles expected below 20000", n);
    end
  endtask

  initial begin
    int n;
    int k;
    repeat (3) @(negedge clk);
    chk("rst_start", 16'(start_inference), 16'd0);
    chk("rst_bank_full", 16'(bank_full), 16'd0);
    chk("rst_frame_error", 16'(frame_error), 16'd0);
    chk("rst_overflow", 16'(overflow), 16'd0);
    chk("rst_pixel", 16'(input_pixel), 16'd0);
    rst_n = 1'b1;

    // First frame: index pattern, start two cycles after the last byte, pixel read-back.
    weights_ready = 1'b1;
    addr_fix = 10'd5;
    send_frame(0, 0);
    @(negedge clk);
    chk("commit_bank_full", 16'(bank_full), 16'h1);
    @(negedge clk);
    chk("start_pulse", 16'(start_inference), 16'd1);
    @(negedge clk);
    chk("start_single", 16'(start_inference), 16'd0);
    chk("pixel_addr5", 16'(input_pixel), 16'h05);
    rand_addr = 1;
    wait_drain();

    // Start withheld until weights are ready.
    weights_ready = 1'b0;
    send_frame(1, 2);
    repeat (3) @(negedge clk);
    chk("held_bank_full", 16'(bank_full), 16'h2);
    weights_ready = 1'b1;
    n = 0;
    repeat (20) begin @(negedge clk); if (start_inference) n++; end
    chk("weights_start_count", 16'(n), 16'd1);
    wait_drain();

    // Partial frame times out after TO idle cycles.
    for (int i = 0; i < 400; i++) send_byte(8'($urandom), (i == 399) ? 0 : $urandom_range(0, 2));
    k = 0;
    while (k < 200 && !frame_error) begin @(negedge clk); k++; end
    chk("timeout_cycles", 16'(k), 16'd100);
    chk("timeout_bank_full", 16'(bank_full), 16'd0);
    send_frame(1, 2);
    wait_drain();

    // Two frames while the engine is busy, third frame's bytes overflow.
    force_busy = 1;
    send_frame(1, 2);
    send_frame(1, 2);
    repeat (3) @(negedge clk);
    chk("both_full", 16'(bank_full), 16'h3);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); rx_valid = 1'b1; rx_data = 8'($urandom);
      @(negedge clk); rx_valid = 1'b0;
      if (overflow) n++;
      @(negedge clk);
    end
    chk("overflow_count", 16'(n), 16'd20);
    force_busy = 0;
    k = 0;
    while (k < 500 && bank_full == 2'b11) begin @(negedge clk); k++; end
    chk("oldest_released_first", 16'(bank_full), 16'h1);
    wait_drain();

`ifdef IMG_CHECKSUM_EN
    begin
      logic [7:0] s;
      logic [7:0] d;
      s = 8'd0;
      for (int i = 0; i < NP; i++) begin
        d = 8'($urandom);
        s = s + d;
        send_byte(d, $urandom_range(0, 2));
      end
      send_byte(s + 8'd1, 0);
      chk("bad_checksum_error", 16'(frame_error), 16'd1);
      repeat (3) @(negedge clk);
      chk("bad_checksum_bank_full", 16'(bank_full), 16'd0);
      send_frame(1, 2);
      wait_drain();
    end
`endif

    // Random mix of frames, partial frames, weights toggling and stray done pulses.
    spurious = 1;
    for (int f = 0; f < 4; f++) begin
      weights_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        n = $urandom_range(1, 300);
        for (int i = 0; i < n; i++) send_byte(8'($urandom), $urandom_range(0, 2));
        repeat (TO + 10) @(negedge clk);
      end else begin
        send_frame(1, $urandom_range(0, 3));
      end
    end
    weights_ready = 1'b1;
    spurious = 0;
    wait_drain();

    // Reset mid-inference and mid-frame, then a fresh frame lands in bank 0.
    hold = 1;
    send_frame(1, 2);
    for (int i = 0; i < 300; i++) send_byte(8'($urandom), $urandom_range(0, 2));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_start", 16'(start_inference), 16'd0);
    chk("mid_rst_bank_full", 16'(bank_full), 16'd0);
    chk("mid_rst_frame_error", 16'(frame_error), 16'd0);
    chk("mid_rst_overflow", 16'(overflow), 16'd0);
    chk("mid_rst_pixel", 16'(input_pixel), 16'd0);
    hold = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_frame(0, 0);
    @(negedge clk);
    chk("post_rst_bank0", 16'(bank_full), 16'h1);
    wait_drain();

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
